// File: rtl/projectile_engine_if.sv
// Bundles the fire, frame and render signals of projectile_engine.
//   master : the producer side (fire buttons, origins, frame tick, raster position)
//            and the consumer of status and render results.
//   slave  : projectile_engine itself.
// Signals:
//   fire_n       active-low fire button per channel
//   origin_x/y   spawn position per channel, channel c at [c*W +: W]
//   frame_tick   frame-update request (level; rising edge acted on)
//   display_col/row  current raster pixel
//   busy         frame update running
//   hit, hit_channel, sprite_x, sprite_y  registered render result
//   active_count number of live slots
//   drop         one-cycle pulse when a fire request found no free slot
//   dbg_state    frame FSM state, for observation only
interface projectile_engine_if #(
  parameter int MAX_SHOTS = 16,
  parameter int CHANNELS  = 2,
  parameter int XW        = 12,
  parameter int YW        = 11,
  parameter int SIZE      = 32
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int SW = $clog2(SIZE);
  localparam int AW = $clog2(MAX_SHOTS) + 1;

  logic [CHANNELS-1:0]    fire_n;
  logic [CHANNELS*XW-1:0] origin_x;
  logic [CHANNELS*YW-1:0] origin_y;
  logic                   frame_tick;
  logic [XW-1:0]          display_col;
  logic [YW-1:0]          display_row;
  logic                   busy;
  logic                   hit;
  logic [CW-1:0]          hit_channel;
  logic [SW-1:0]          sprite_x;
  logic [SW-1:0]          sprite_y;
  logic [AW-1:0]          active_count;
  logic                   drop;
  logic [1:0]             dbg_state;

  modport master (
    output fire_n, origin_x, origin_y, frame_tick, display_col, display_row,
    input  busy, hit, hit_channel, sprite_x, sprite_y, active_count, drop, dbg_state
  );

  modport slave (
    input  fire_n, origin_x, origin_y, frame_tick, display_col, display_row,
    output busy, hit, hit_channel, sprite_x, sprite_y, active_count, drop, dbg_state
  );
endinterface

// File: rtl/projectile_engine.sv
// Multi-channel projectile manager.
// Each channel's fire button edge becomes a pending request carrying the origin
// latched at the edge. On a frame_tick rising edge the frame FSM spends CHANNELS
// cycles inserting pending requests into the lowest free slots, then MAX_SHOTS
// cycles moving slot i on cycle i (even channels up, odd channels down) and
// retiring shots that leave the playfield. Every cycle the raster position is
// tested against all live slots and the lowest-index covering shot is reported
// one cycle later.
// Ports:
//   clock  system clock
//   reset  synchronous, active-high
//   bus    projectile_engine_if.slave (fire/frame inputs, render and status outputs)
//
// Request protocol: a fire request is raised by a 1->0 edge of fire_n[c] and is
// held in pending[c] until that channel's INSERT cycle consumes it (inserted or
// dropped). Edges arriving while a request is held are ignored, except an edge
// in the very cycle the request is consumed, which becomes the new request.
module projectile_engine #(
  parameter int MAX_SHOTS = 16,
  parameter int CHANNELS  = 2,
  parameter int XW        = 12,
  parameter int YW        = 11,
  parameter int SIZE      = 32,
  parameter int SPEED     = 8,
  parameter int Y_LIMIT   = 1200
) (
  input logic              clock,
  input logic              reset,
  projectile_engine_if.slave bus
);
  localparam int CW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int SW  = $clog2(SIZE);
  localparam int AW  = $clog2(MAX_SHOTS) + 1;
  localparam int SLW = $clog2(MAX_SHOTS);
  localparam int IW  = $clog2(MAX_SHOTS + CHANNELS) + 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_INSERT = 2'd1;
  localparam logic [1:0] ST_MOVE   = 2'd2;

  logic [1:0]          state;
  logic [IW-1:0]       step;
  logic [CHANNELS-1:0] fire_q;
  logic                tick_q;
  logic [CHANNELS-1:0] pending;
  logic [XW-1:0]       lat_x [CHANNELS];
  logic [YW-1:0]       lat_y [CHANNELS];

  logic [MAX_SHOTS-1:0] slot_valid;
  logic [XW-1:0]        slot_x  [MAX_SHOTS];
  logic [YW-1:0]        slot_y  [MAX_SHOTS];
  logic [CW-1:0]        slot_ch [MAX_SHOTS];

  logic          drop_r;
  logic [AW-1:0] active_r;
  logic          hit_r;
  logic [CW-1:0] hit_ch_r;
  logic [SW-1:0] spr_x_r;
  logic [SW-1:0] spr_y_r;

  // ---------------- request capture ----------------
  logic [CHANNELS-1:0] fire_edge;
  logic                tick_rise;
  logic [CW-1:0]       ins_ch;
  logic                ins_pending;
  logic [CHANNELS-1:0] ins_clear;
  logic [CHANNELS-1:0] capture;

  assign fire_edge   = fire_q & ~bus.fire_n;
  assign tick_rise   = bus.frame_tick & ~tick_q;
  assign ins_ch      = step[CW-1:0];
  assign ins_pending = (state == ST_INSERT) && pending[ins_ch];

  always_comb begin
    ins_clear = '0;
    if (ins_pending) ins_clear[ins_ch] = 1'b1;
  end

  // A request being consumed this cycle frees the channel for a coincident edge.
  assign capture = fire_edge & (~pending | ins_clear);

  // ---------------- free slot search (lowest index) ----------------
  logic           free_found;
  logic [SLW-1:0] free_idx;

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = MAX_SHOTS - 1; i >= 0; i--) begin
      if (!slot_valid[i]) begin
        free_found = 1'b1;
        free_idx   = SLW'(i);
      end
    end
  end

  // ---------------- move step for the slot selected by step ----------------
  logic [SLW-1:0] mv_slot;
  logic           mv_live;
  logic           mv_up;
  logic [YW:0]    y_down;
  logic           mv_kill;

  assign mv_slot = step[SLW-1:0];
  assign mv_live = (state == ST_MOVE) && slot_valid[mv_slot];
  assign mv_up   = ~slot_ch[mv_slot][0];
  // One extra bit so a shot near the bottom cannot wrap back to the top.
  assign y_down  = {1'b0, slot_y[mv_slot]} + (YW+1)'(SPEED);
  assign mv_kill = mv_up ? (slot_y[mv_slot] < YW'(SPEED))
                         : (y_down > (YW+1)'(Y_LIMIT));

  // ---------------- popcount ----------------
  logic [AW-1:0] valid_cnt;

  always_comb begin
    valid_cnt = '0;
    for (int i = 0; i < MAX_SHOTS; i++) valid_cnt = valid_cnt + AW'(slot_valid[i]);
  end

  // ---------------- control and valid bits ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      step       <= '0;
      fire_q     <= '1;
      tick_q     <= 1'b0;
      pending    <= '0;
      slot_valid <= '0;
      drop_r     <= 1'b0;
      active_r   <= '0;
    end else begin
      fire_q   <= bus.fire_n;
      tick_q   <= bus.frame_tick;
      active_r <= valid_cnt;
      drop_r   <= ins_pending && !free_found;

      for (int c = 0; c < CHANNELS; c++) begin
        if (capture[c])        pending[c] <= 1'b1;
        else if (ins_clear[c]) pending[c] <= 1'b0;
      end

      if (ins_pending && free_found) slot_valid[free_idx] <= 1'b1;
      if (mv_live && mv_kill)        slot_valid[mv_slot]  <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (tick_rise) begin
            state <= ST_INSERT;
            step  <= '0;
          end
        end
        ST_INSERT: begin
          if (step == IW'(CHANNELS - 1)) begin
            state <= ST_MOVE;
            step  <= '0;
          end else begin
            step <= step + 1'b1;
          end
        end
        ST_MOVE: begin
          if (step == IW'(MAX_SHOTS - 1)) begin
            state <= ST_IDLE;
            step  <= '0;
          end else begin
            step <= step + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          step  <= '0;
        end
      endcase
    end
  end

  // ---------------- slot and origin payload (no reset needed) ----------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (capture[c]) begin
          lat_x[c] <= bus.origin_x[c*XW +: XW];
          lat_y[c] <= bus.origin_y[c*YW +: YW];
        end
      end
      if (ins_pending && free_found) begin
        slot_x[free_idx]  <= lat_x[ins_ch];
        slot_y[free_idx]  <= lat_y[ins_ch];
        slot_ch[free_idx] <= ins_ch;
      end
      if (mv_live && !mv_kill) begin
        slot_y[mv_slot] <= mv_up ? (slot_y[mv_slot] - YW'(SPEED)) : y_down[YW-1:0];
      end
    end
  end

  // ---------------- render path ----------------
  logic           r_hit;
  logic [SLW-1:0] r_idx;

  // Compare at one extra bit so a shot near the right/bottom edge does not wrap.
  always_comb begin
    r_hit = 1'b0;
    r_idx = '0;
    for (int i = MAX_SHOTS - 1; i >= 0; i--) begin
      if (slot_valid[i]
          && ({1'b0, bus.display_col} >= {1'b0, slot_x[i]})
          && ({1'b0, bus.display_col} <  ({1'b0, slot_x[i]} + (XW+1)'(SIZE)))
          && ({1'b0, bus.display_row} >= {1'b0, slot_y[i]})
          && ({1'b0, bus.display_row} <  ({1'b0, slot_y[i]} + (YW+1)'(SIZE)))) begin
        r_hit = 1'b1;
        r_idx = SLW'(i);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hit_r    <= 1'b0;
      hit_ch_r <= '0;
      spr_x_r  <= '0;
      spr_y_r  <= '0;
    end else begin
      hit_r    <= r_hit;
      hit_ch_r <= r_hit ? slot_ch[r_idx] : '0;
      spr_x_r  <= r_hit ? SW'(bus.display_col - slot_x[r_idx]) : '0;
      spr_y_r  <= r_hit ? SW'(bus.display_row - slot_y[r_idx]) : '0;
    end
  end

  assign bus.busy         = (state != ST_IDLE);
  assign bus.hit          = hit_r;
  assign bus.hit_channel  = hit_ch_r;
  assign bus.sprite_x     = spr_x_r;
  assign bus.sprite_y     = spr_y_r;
  assign bus.active_count = active_r;
  assign bus.drop         = drop_r;
  assign bus.dbg_state    = state;
endmodule

// File: tb/tb_projectile_engine.sv
// Bench for projectile_engine: directed scenarios followed by random traffic,
// with a shot-list model checked against the DUT on every falling edge.
module tb_projectile_engine;
  localparam int MAX_SHOTS = 16;
  localparam int CHANNELS  = 2;
  localparam int XW        = 12;
  localparam int YW        = 11;
  localparam int SIZE      = 32;
  localparam int SPEED     = 8;
  localparam int Y_LIMIT   = 1200;
  localparam int FRAME_LEN = CHANNELS + MAX_SHOTS;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  projectile_engine_if #(.MAX_SHOTS(MAX_SHOTS), .CHANNELS(CHANNELS), .XW(XW), .YW(YW),
                         .SIZE(SIZE)) bus ();

  projectile_engine #(.MAX_SHOTS(MAX_SHOTS), .CHANNELS(CHANNELS), .XW(XW), .YW(YW),
                      .SIZE(SIZE), .SPEED(SPEED), .Y_LIMIT(Y_LIMIT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  // Shot list plus pending requests; a frame is a countdown of cycles where
  // the first CHANNELS cycles insert channel k and the rest move slot k-CHANNELS.
  int m_valid [MAX_SHOTS];
  int m_x     [MAX_SHOTS];
  int m_y     [MAX_SHOTS];
  int m_ch    [MAX_SHOTS];
  int m_pend  [CHANNELS];
  int m_ox    [CHANNELS];
  int m_oy    [CHANNELS];
  int m_phase;
  logic [CHANNELS-1:0] m_fire_prev;
  logic m_tick_prev;
  int e_hit, e_ch, e_sx, e_sy, e_busy, e_active, e_drop;
  bit model_live = 1'b0;

  task automatic model_reset();
    for (int i = 0; i < MAX_SHOTS; i++) m_valid[i] = 0;
    for (int c = 0; c < CHANNELS; c++) m_pend[c] = 0;
    m_phase = -1;
    m_fire_prev = '1;
    m_tick_prev = 1'b0;
    e_hit = 0; e_ch = 0; e_sx = 0; e_sy = 0; e_busy = 0; e_active = 0; e_drop = 0;
  endtask

  task automatic model_step();
    int col, row, hit_i, n, c, s, f;
    logic [CHANNELS-1:0] edges;
    col = int'(bus.display_col);
    row = int'(bus.display_row);
    hit_i = -1;
    for (int i = 0; i < MAX_SHOTS; i++)
      if (hit_i < 0 && m_valid[i] != 0 && col >= m_x[i] && col < m_x[i] + SIZE
          && row >= m_y[i] && row < m_y[i] + SIZE) hit_i = i;
    e_hit = (hit_i >= 0) ? 1 : 0;
    e_ch  = (hit_i >= 0) ? m_ch[hit_i] : 0;
    e_sx  = (hit_i >= 0) ? col - m_x[hit_i] : 0;
    e_sy  = (hit_i >= 0) ? row - m_y[hit_i] : 0;
    n = 0;
    for (int i = 0; i < MAX_SHOTS; i++) n += m_valid[i];
    e_active = n;
    e_drop = 0;
    edges = m_fire_prev & ~bus.fire_n;

    if (m_phase < 0) begin
      if (bus.frame_tick && !m_tick_prev) m_phase = 0;
    end else begin
      if (m_phase < CHANNELS) begin
        c = m_phase;
        if (m_pend[c] != 0) begin
          f = -1;
          for (int i = 0; i < MAX_SHOTS; i++) if (f < 0 && m_valid[i] == 0) f = i;
          if (f >= 0) begin
            m_valid[f] = 1; m_x[f] = m_ox[c]; m_y[f] = m_oy[c]; m_ch[f] = c;
          end else begin
            e_drop = 1;
          end
          m_pend[c] = 0;
        end
      end else begin
        s = m_phase - CHANNELS;
        if (m_valid[s] != 0) begin
          if (m_ch[s] % 2 == 0) begin
            if (m_y[s] < SPEED) m_valid[s] = 0; else m_y[s] = m_y[s] - SPEED;
          end else begin
            if (m_y[s] + SPEED > Y_LIMIT) m_valid[s] = 0; else m_y[s] = m_y[s] + SPEED;
          end
        end
      end
      m_phase++;
      if (m_phase == FRAME_LEN) m_phase = -1;
    end

    for (int k = 0; k < CHANNELS; k++) begin
      if (edges[k] && m_pend[k] == 0) begin
        m_pend[k] = 1;
        m_ox[k] = int'(bus.origin_x[k*XW +: XW]);
        m_oy[k] = int'(bus.origin_y[k*YW +: YW]);
      end
    end
    m_fire_prev = bus.fire_n;
    m_tick_prev = bus.frame_tick;
    e_busy = (m_phase >= 0) ? 1 : 0;
  endtask

  always @(posedge clock) begin
    if (reset) model_reset();
    else model_step();
    model_live = 1'b1;
  end

  // ---------------- compare process ----------------
  always @(negedge clock) begin
    if (model_live) begin
      check("busy", bus.busy, e_busy);
      check("hit", bus.hit, e_hit);
      check("hit_channel", bus.hit_channel, e_ch);
      check("sprite_x", bus.sprite_x, e_sx);
      check("sprite_y", bus.sprite_y, e_sy);
      check("active_count", bus.active_count, e_active);
      check("drop", bus.drop, e_drop);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic fire(input int c, input int x, input int y);
    @(negedge clock);
    bus.origin_x[c*XW +: XW] = XW'(x);
    bus.origin_y[c*YW +: YW] = YW'(y);
    bus.fire_n[c] = 1'b0;
    @(negedge clock);
    bus.fire_n[c] = 1'b1;
  endtask

  task automatic fire_both(input int x0, input int y0, input int x1, input int y1);
    @(negedge clock);
    bus.origin_x = {XW'(x1), XW'(x0)};
    bus.origin_y = {YW'(y1), YW'(y0)};
    bus.fire_n = '0;
    @(negedge clock);
    bus.fire_n = '1;
  endtask

  // Pulses frame_tick and returns the number of cycles busy stayed high.
  task automatic frame(output int len);
    @(negedge clock);
    bus.frame_tick = 1'b1;
    @(negedge clock);
    bus.frame_tick = 1'b0;
    len = 0;
    while (bus.busy && len < 200) begin
      len++;
      @(negedge clock);
    end
  endtask

  task automatic set_pix(input int col, input int row);
    @(negedge clock);
    bus.display_col = XW'(col);
    bus.display_row = YW'(row);
    @(negedge clock);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int len, drops, s, r;
    bus.fire_n = '1;
    bus.origin_x = '0;
    bus.origin_y = '0;
    bus.frame_tick = 1'b0;
    bus.display_col = '0;
    bus.display_row = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Idle after reset
    repeat (50) @(negedge clock);
    check("idle_busy", bus.busy, 0);
    check("idle_active", bus.active_count, 0);

    // Single up shot
    fire(0, 100, 500);
    frame(len);
    check("frame_len", len, 18);
    check("up_active", bus.active_count, 1);
    check("model_y0", m_y[0], 492);
    check("model_x0", m_x[0], 100);
    set_pix(110, 500);
    check("pix_hit", bus.hit, 1);
    check("pix_ch", bus.hit_channel, 0);
    check("pix_sx", bus.sprite_x, 10);
    check("pix_sy", bus.sprite_y, 8);
    set_pix(132, 500);
    check("pix_edge_miss", bus.hit, 0);

    // Down shot near the lower limit
    do_reset();
    fire(1, 40, 1190);
    frame(len);
    check("model_down_y", m_y[0], 1198);
    set_pix(71, 1229);
    check("down_hit", bus.hit, 1);
    check("down_ch", bus.hit_channel, 1);
    check("down_sx", bus.sprite_x, 31);
    check("down_sy", bus.sprite_y, 31);
    frame(len);
    check("down_retired", bus.active_count, 0);

    // Up shot retired on its first move
    do_reset();
    fire(0, 10, 5);
    frame(len);
    check("up_retired", bus.active_count, 0);

    // No horizontal wrap near the right edge
    do_reset();
    fire(0, 4080, 600);
    frame(len);
    set_pix(4095, 600);
    check("wrap_hit", bus.hit, 1);
    check("wrap_sx", bus.sprite_x, 15);
    set_pix(5, 600);
    check("wrap_miss", bus.hit, 0);

    // Overlapping shots: lowest slot wins
    do_reset();
    fire_both(100, 500, 110, 480);
    frame(len);
    set_pix(115, 495);
    check("prio_ch", bus.hit_channel, 0);
    check("prio_sx", bus.sprite_x, 15);
    check("prio_sy", bus.sprite_y, 3);

    // Fill all slots, then overflow
    do_reset();
    for (int k = 0; k < 8; k++) begin
      fire_both(300 + 20 * k, 1000, 300 + 20 * k, 100);
      frame(len);
    end
    check("full_active", bus.active_count, 16);
    fire_both(50, 700, 60, 300);
    @(negedge clock);
    bus.frame_tick = 1'b1;
    drops = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      bus.frame_tick = 1'b0;
      if (bus.drop) drops++;
    end
    check("drop_count", drops, 2);
    check("full_after_drop", bus.active_count, 16);
    @(negedge clock);
    bus.frame_tick = 1'b1;
    drops = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      bus.frame_tick = 1'b0;
      if (bus.drop) drops++;
    end
    check("no_stale_pending", drops, 0);

    // Second tick during busy is ignored
    @(negedge clock);
    bus.frame_tick = 1'b1;
    @(negedge clock);
    bus.frame_tick = 1'b0;
    len = 0;
    while (bus.busy && len < 200) begin
      len++;
      if (len == 5) bus.frame_tick = 1'b1;
      if (len == 7) bus.frame_tick = 1'b0;
      @(negedge clock);
    end
    check("retick_len", len, 18);
    repeat (3) begin
      @(negedge clock);
      check("retick_idle", bus.busy, 0);
    end

    // Reset on MOVE cycle 5
    do_reset();
    fire(0, 300, 900);
    frame(len);
    set_pix(300, 892);
    check("pre_reset_hit", bus.hit, 1);
    bus.frame_tick = 1'b1;
    @(negedge clock);
    bus.frame_tick = 1'b0;
    repeat (CHANNELS + 5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("abort_busy", bus.busy, 0);
    check("abort_active", bus.active_count, 0);
    check("abort_hit", bus.hit, 0);
    reset = 1'b0;

    // Fire edge coincident with the INSERT cycle of its channel
    fire(0, 200, 700);
    @(negedge clock);
    bus.frame_tick = 1'b1;
    @(negedge clock);
    bus.frame_tick = 1'b0;
    bus.origin_x[0 +: XW] = XW'(600);
    bus.origin_y[0 +: YW] = YW'(800);
    bus.fire_n[0] = 1'b0;
    @(negedge clock);
    bus.fire_n[0] = 1'b1;
    len = 0;
    while (bus.busy && len < 200) begin
      len++;
      @(negedge clock);
    end
    check("coinc_active1", bus.active_count, 1);
    check("coinc_pending", m_pend[0], 1);
    frame(len);
    check("coinc_active2", bus.active_count, 2);
    set_pix(600, 792);
    check("coinc_hit", bus.hit, 1);
    check("coinc_sx", bus.sprite_x, 0);
    check("coinc_sy", bus.sprite_y, 0);

    // Random traffic
    do_reset();
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 2) begin
        fire($urandom_range(0, CHANNELS - 1), $urandom_range(0, 4095),
             ($urandom_range(0, 1) != 0) ? $urandom_range(0, 1250) : $urandom_range(0, 2047));
      end else if (r == 3) begin
        @(negedge clock);
        bus.origin_x = CHANNELS*XW'($urandom);
        bus.origin_y = CHANNELS*YW'($urandom);
        bus.fire_n = CHANNELS'($urandom);
      end else if (r <= 5) begin
        @(negedge clock);
        bus.frame_tick = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clock);
        bus.frame_tick = 1'b0;
      end else if (r <= 8) begin
        s = $urandom_range(0, MAX_SHOTS - 1);
        @(negedge clock);
        if (m_valid[s] != 0) begin
          bus.display_col = XW'(m_x[s] + $urandom_range(0, SIZE + 3) - 2);
          bus.display_row = YW'(m_y[s] + $urandom_range(0, SIZE + 3) - 2);
        end else begin
          bus.display_col = XW'($urandom);
          bus.display_row = YW'($urandom);
        end
      end else begin
        repeat ($urandom_range(1, 4)) @(negedge clock);
      end
    end
    bus.fire_n = '1;
    bus.frame_tick = 1'b0;
    len = 0;
    while (bus.busy && len < 200) begin
      len++;
      @(negedge clock);
    end
    if (len >= 200) check("final_busy_timeout", bus.busy, 0);
    repeat (5) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/projectile_engine.md
Name: projectile_engine

Overview:
- Multi-channel projectile manager. It generalises the single-player bullet block to CHANNELS independent fire sources, each with its own travel direction.
- Slot storage is a register array of depth MAX_SHOTS with a parametrised sprite size, speed and playfield limit.
- Each frame it inserts pending shots, advances every live shot and retires off-screen ones.
- Every pixel clock it reports a hit flag plus sprite-local coordinates to the downstream sprite ROM and colour mixer.

Parameters:
- MAX_SHOTS, 16, number of projectile slots (power of two, 4..64).
- CHANNELS, 2, number of fire sources. Even channels travel up (y decreasing); odd channels travel down.
- XW, 12, x coordinate / display_col width.
- YW, 11, y coordinate / display_row width.
- SIZE, 32, square sprite edge in pixels (power of two).
- SPEED, 8, pixels moved per frame.
- Y_LIMIT, 1200, lowest permitted y for downward shots.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- fire_n  in  CHANNELS  active-low fire button per channel
- origin_x  in  CHANNELS*XW  spawn x per channel; channel c occupies bits [c*XW +: XW]
- origin_y  in  CHANNELS*YW  spawn y per channel
- frame_tick  in  1  frame-update request, level; rising edge is acted on
- display_col  in  XW  current pixel column
- display_row  in  YW  current pixel row
- busy  out  1  high while the frame update runs
- hit  out  1  current pixel lies inside a live shot
- hit_channel  out  max(1,$clog2(CHANNELS))  owner of the hitting shot
- sprite_x  out  $clog2(SIZE)  display_col minus shot x
- sprite_y  out  $clog2(SIZE)  display_row minus shot y
- active_count  out  $clog2(MAX_SHOTS)+1  number of valid slots
- drop  out  1  one-cycle pulse when a request is lost because all slots are full

Behaviour:
- Reset:
  - All slots invalid; pending flags cleared; fire_n history set to all-ones; frame_tick history set to 0; state IDLE.
  - Outputs busy, hit, hit_channel, sprite_x, sprite_y, active_count and drop are all 0.
  - Reset asserted mid-update aborts the update immediately, with the same values.
- Fire capture:
  - A 1→0 transition of fire_n[c] (compared with the previous-cycle sample) sets pending[c] and latches origin_x/origin_y for channel c.
  - An edge while pending[c] is already set is ignored; the first origin is kept.
  - An edge in the same cycle that INSERT clears pending[c] leaves pending[c] set, carrying the new origin.
- Slot format: valid, x[XW], y[YW], channel index.
- Frame FSM: IDLE → INSERT → MOVE → IDLE.
  - IDLE: a frame_tick rising edge moves the FSM to INSERT next cycle and raises busy. Ticks seen outside IDLE are ignored.
  - INSERT: runs CHANNELS cycles, channel 0 first.
    - If pending[c] is set, the lowest-index invalid slot is written with the latched origin and pending[c] clears.
    - If no slot is free, pending[c] clears and drop pulses for one cycle.
    - A slot filled in one INSERT cycle counts as occupied for the later channels.
  - MOVE: runs MAX_SHOTS cycles, slot i on MOVE cycle i. Shots inserted this frame also move this frame.
    - Up shot: if y < SPEED, invalidate; else y ← y − SPEED.
    - Down shot: if y + SPEED > Y_LIMIT, invalidate; else y ← y + SPEED. Compute at YW+1 bits, no wrap.
  - busy is high for exactly CHANNELS+MAX_SHOTS cycles, beginning the cycle after the tick edge is detected.
- active_count: registered, equal to the popcount of the valid bits one cycle after any slot change.
- Render path (1-cycle latency):
  - A shot covers the pixel when display_col ∈ [x, x+SIZE) and display_row ∈ [y, y+SIZE). Compare at widened widths so a shot near the maximum coordinate does not wrap.
  - Among covering shots, the lowest slot index wins.
  - hit, hit_channel, sprite_x and sprite_y are registered from the values sampled in the same cycle.
  - With no hit, hit=0 and sprite_x, sprite_y and hit_channel are 0.
  - Rendering continues during busy and uses the slot contents as of that cycle.
- Slot order is not sorted. Render priority is by index only.

Test Plan:
- Reset then idle 50 cycles → hit=0, busy=0, active_count=0, drop=0 throughout.
- Channel 0 fire edge, origin (100,500), one frame_tick → busy high 18 cycles (defaults); slot0 = (100,492), active_count=1. Then pixel (110,500) → one cycle later hit=1, hit_channel=0, sprite_x=10, sprite_y=8. Pixel (132,500) → hit=0.
- Channel 1 fire, origin (40,1190), frame_tick → shot at y=1198. Second frame_tick → shot retired (1206>1200), active_count=0.
- Channel 0 fire, origin y=5, frame_tick → shot retired in MOVE (5<8), active_count returns to 0.
- Fill all 16 slots, then fire on both channels and issue frame_tick → drop pulses in exactly two cycles (one per channel), active_count stays 16, both pending flags clear.
- Cross-cutting edge cases:
  - Second frame_tick during busy → ignored, busy length unchanged.
  - Reset asserted on MOVE cycle 5 → next cycle busy=0, active_count=0, hit=0.
  - Fire edge coincident with the INSERT cycle that clears the same channel → request remains pending and is inserted in the next frame.
